// File: rtl/clken_pkg.sv
// clken_pkg: shared types and defaults for the clock-enable generator
package clken_pkg;
    localparam int CNT_W       = 8;
    localparam int DEFAULT_DIV = 6;
    typedef enum logic [1:0] {RUN, DRAIN, PAUSED, STEP} state_e;
endpackage

// File: rtl/clken_channel.sv
// clken_channel: one programmable-period enable channel with glitch-free divisor reload
module clken_channel #(
    parameter int W   = clken_pkg::CNT_W,
    parameter int DEF = clken_pkg::DEFAULT_DIV
) (
    input  logic         sys_clock,
    input  logic         reset,
    input  logic         advance,
    input  logic         ch_enable,
    input  logic [W-1:0] div_in,
    input  logic         div_load,
    output logic         clken,
    output logic [W-1:0] active,
    output logic         at_zero,
    output logic         at_end
);
    logic [W-1:0] cnt_q, cnt_d, pend_q, pend_d, active_q, active_d;
    logic         clken_q, clken_d;
    logic         wrap;

    assign wrap    = advance && ch_enable && cnt_q >= active_q;
    assign at_zero = cnt_q == '0;
    assign at_end  = cnt_q >= active_q;
    assign clken   = clken_q;
    assign active  = active_q;

    // Next state: a disabled channel parks at 0 and tracks the pending divisor; the divisor only swaps on a wrap
    always_comb begin
        pend_d   = div_load ? div_in : pend_q;
        cnt_d    = !ch_enable ? '0 : !advance ? cnt_q : wrap ? '0 : cnt_q + 1'b1;
        active_d = (!ch_enable || wrap) ? pend_q : active_q;
        clken_d  = ch_enable && advance && at_zero;
    end

    // Channel registers
    always_ff @(posedge sys_clock or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            pend_q   <= W'(DEF);
            active_q <= W'(DEF);
            clken_q  <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            active_q <= active_d;
            clken_q  <= clken_d;
        end
    end
endmodule

// File: rtl/clken_gen.sv
// clken_gen: multi-channel clock-enable generator with pause/single-step on channel-0 boundaries
module clken_gen #(
    parameter int NUM_CH      = 3,
    parameter int CNT_W       = clken_pkg::CNT_W,
    parameter int DEFAULT_DIV = clken_pkg::DEFAULT_DIV
) (
    input  logic                    sys_clock,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       ch_enable,
    input  logic [NUM_CH*CNT_W-1:0] div_in,
    input  logic [NUM_CH-1:0]       div_load,
    input  logic                    pause_req,
    input  logic                    step,
    output logic [NUM_CH-1:0]       clken,
    output logic                    pause_ack,
    output logic [NUM_CH*CNT_W-1:0] div_active
);
    import clken_pkg::*;

    state_e              state_q, state_d;
    logic                advance, ack_q;
    logic [NUM_CH-1:0]   at_zero, at_end;
    logic                unused_status;

    assign pause_ack     = ack_q;
    assign unused_status = ^{at_zero, at_end};

    // Pause FSM: only channel 0 decides where a freeze may start and where a step ends
    always_comb begin
        state_d = state_q;
        advance = 1'b1;
        unique case (state_q)
            RUN:     state_d = pause_req ? DRAIN : RUN;
            DRAIN: begin
                advance = !at_zero[0];
                state_d = !pause_req ? RUN : at_zero[0] ? PAUSED : DRAIN;
            end
            PAUSED: begin
                advance = 1'b0;
                state_d = !pause_req ? RUN : step ? STEP : PAUSED;
            end
            STEP:    state_d = (at_end[0] || !ch_enable[0]) ? PAUSED : STEP;
            default: state_d = RUN;
        endcase
    end

    // FSM state and registered acknowledge
    always_ff @(posedge sys_clock or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_q   <= state_d == PAUSED;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clken_channel #(.W(CNT_W), .DEF(DEFAULT_DIV)) u_ch (
            .sys_clock (sys_clock),
            .reset     (reset),
            .advance   (advance),
            .ch_enable (ch_enable[i]),
            .div_in    (div_in[i*CNT_W +: CNT_W]),
            .div_load  (div_load[i]),
            .clken     (clken[i]),
            .active    (div_active[i*CNT_W +: CNT_W]),
            .at_zero   (at_zero[i]),
            .at_end    (at_end[i])
        );
    end
endmodule

// File: tb/tb_clken_gen.sv
// tb_clken_gen: directed plus randomized check of clken_gen against a period-level model
module tb_clken_gen;
    localparam int N = 3;
    localparam int W = 8;
    localparam int M_RUN = 0, M_DRAIN = 1, M_PAUSED = 2, M_STEP = 3;

    logic           sys_clock = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   ch_enable = '1, div_load = '0, clken;
    logic [N*W-1:0] div_in = '0, div_active;
    logic           pause_req = 1'b0, step = 1'b0, pause_ack;

    int errors = 0, checks = 0;

    int       pos[N], act[N], pend[N];
    logic [N-1:0] m_clk;
    int       mode;
    logic     m_ack;

    always #5 sys_clock = ~sys_clock;

    clken_gen #(.NUM_CH(N), .CNT_W(W), .DEFAULT_DIV(6)) dut (
        .sys_clock  (sys_clock),
        .reset      (reset),
        .ch_enable  (ch_enable),
        .div_in     (div_in),
        .div_load   (div_load),
        .pause_req  (pause_req),
        .step       (step),
        .clken      (clken),
        .pause_ack  (pause_ack),
        .div_active (div_active)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            pos[i] = 0; act[i] = 6; pend[i] = 6;
        end
        m_clk = '0; mode = M_RUN; m_ack = 1'b0;
    endfunction

    // pos = cycles elapsed in the current period; a period spans act+1 cycles and pulses at its first cycle
    function automatic void model_edge();
        bit run;
        int nxt;
        run = (mode == M_RUN || mode == M_STEP) ? 1'b1 : (mode == M_DRAIN) ? (pos[0] != 0) : 1'b0;
        case (mode)
            M_RUN:    nxt = pause_req ? M_DRAIN : M_RUN;
            M_DRAIN:  nxt = !pause_req ? M_RUN : (pos[0] == 0) ? M_PAUSED : M_DRAIN;
            M_PAUSED: nxt = !pause_req ? M_RUN : step ? M_STEP : M_PAUSED;
            default:  nxt = (pos[0] == act[0] || !ch_enable[0]) ? M_PAUSED : M_STEP;
        endcase
        for (int i = 0; i < N; i++) begin
            if (!ch_enable[i]) begin
                m_clk[i] = 1'b0; pos[i] = 0; act[i] = pend[i];
            end else if (run) begin
                m_clk[i] = (pos[i] == 0);
                if (pos[i] == act[i]) begin
                    pos[i] = 0; act[i] = pend[i];
                end else pos[i]++;
            end else m_clk[i] = 1'b0;
        end
        for (int i = 0; i < N; i++) if (div_load[i]) pend[i] = int'(div_in[i*W +: W]);
        mode = nxt;
        m_ack = (mode == M_PAUSED);
    endfunction

    task automatic compare_all();
        check("clken", 32'(clken), 32'(m_clk));
        check("pause_ack", 32'(pause_ack), 32'(m_ack));
        for (int i = 0; i < N; i++) check("div_active", 32'(div_active[i*W +: W]), act[i]);
    endtask

    task automatic tick();
        @(posedge sys_clock);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic wait_ack();
        int n = 0;
        while (!pause_ack && n < 30) begin
            tick();
            n++;
        end
        check("ack_timeout", 32'(pause_ack), 1);
    endtask

    initial begin
        int cnt_p, cnt_l;
        model_reset();
        #12;
        check("rst_clken", 32'(clken), 0);
        check("rst_ack", 32'(pause_ack), 0);
        for (int i = 0; i < N; i++) check("rst_div", 32'(div_active[i*W +: W]), 6);
        reset = 1'b0;
        for (int e = 1; e <= 22; e++) begin
            tick();
            check("ch0_edge", 32'(clken[0]), 32'((e % 7) == 1));
        end
        tick(); tick();
        div_load = 3'b010; div_in[W +: W] = 8'd2;
        tick();
        div_load = '0;
        tick(); tick();
        check("div1_hold", 32'(div_active[W +: W]), 6);
        tick();
        check("div1_swap", 32'(div_active[W +: W]), 2);
        repeat (12) tick();
        div_load = 3'b100; div_in[2*W +: W] = 8'd0;
        tick();
        div_load = '0;
        repeat (10) tick();
        check("div0_const", 32'(clken[2]), 1);
        ch_enable[2] = 1'b0;
        tick();
        check("ch2_off", 32'(clken[2]), 0);
        ch_enable[2] = 1'b1;
        tick();
        check("ch2_reen", 32'(clken[2]), 1);
        repeat (3) tick();
        pause_req = 1'b1;
        wait_ack();
        repeat (100) tick();
        check("paused_quiet", 32'(clken), 0);
        cnt_p = 0; cnt_l = 0;
        for (int k = 0; k < 3; k++) begin
            step = 1'b1;
            tick();
            step = 1'b0;
            cnt_l += !pause_ack;
            for (int j = 0; j < 19; j++) begin
                tick();
                cnt_p += clken[0];
                cnt_l += !pause_ack;
            end
        end
        check("step_pulses", cnt_p, 3);
        check("step_ack_low", cnt_l, 21);
        pause_req = 1'b0; step = 1'b1;
        tick();
        step = 1'b0;
        check("resume_run", 32'(pause_ack), 0);
        cnt_p = 0;
        repeat (21) begin
            tick();
            cnt_p += clken[0];
        end
        check("resume_pulses", cnt_p, 3);
        pause_req = 1'b1;
        wait_ack();
        step = 1'b1;
        tick();
        step = 1'b0;
        tick(); tick();
        reset = 1'b1;
        #1;
        model_reset();
        compare_all();
        @(posedge sys_clock);
        #1;
        compare_all();
        pause_req = 1'b0;
        reset = 1'b0;
        repeat (3000) begin
            for (int i = 0; i < N; i++) begin
                ch_enable[i] = $urandom_range(0, 7) != 0;
                div_load[i]  = $urandom_range(0, 15) == 0;
                div_in[i*W +: W] = 8'($urandom_range(0, 9));
            end
            if ($urandom_range(0, 39) == 0) pause_req = ~pause_req;
            step = $urandom_range(0, 7) == 0;
            tick();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/clken_gen.md
Name: clken_gen

Overview:
- Parametrised multi-channel clock-enable generator.
- Each channel derives a one-cycle enable pulse from sys_clock with a run-time programmable integer period.
- Channel 0 is the CPU/device enable. Channels 1..NUM_CH-1 serve video, serial and audio timing.
- A pause/single-step handshake freezes all channels on a channel-0 period boundary, for the debugger and the turbo/stall logic.

Parameters:
- NUM_CH, 3, number of enable channels (>=1).
- CNT_W, 8, counter and divisor width per channel.
- DEFAULT_DIV, 6, reset divisor for every channel (period = DEFAULT_DIV+1 = 7 sys_clock cycles).

Ports:
- sys_clock  in  1  master clock.
- reset  in  1  asynchronous, active-high.
- ch_enable  in  NUM_CH  per-channel run gate.
- div_in  in  NUM_CH*CNT_W  divisor per channel; slice i = bits [i*CNT_W +: CNT_W].
- div_load  in  NUM_CH  per-channel strobe; captures div_in slice into the pending register.
- pause_req  in  1  level request to freeze all channels.
- step  in  1  one-cycle pulse; while paused, run exactly one channel-0 period.
- clken  out  NUM_CH  registered enable pulses.
- pause_ack  out  1  high while frozen.
- div_active  out  NUM_CH*CNT_W  divisor currently in effect per channel.

Behaviour:
- Reset is asynchronous on reset; clock is sys_clock.
- Reset values:
  - cnt[i] = 0; pend[i] = active[i] = DEFAULT_DIV.
  - clken = 0; pause_ack = 0; state = RUN.
  - Reset asserted mid-operation (including DRAIN/PAUSED/STEP) returns immediately to these values.
- Per channel, when advancing:
  - clken[i] <= (cnt[i]==0); the pulse appears one edge after the counter holds 0.
  - cnt[i] <= (cnt[i] >= active[i]) ? 0 : cnt[i]+1.
  - Period = active[i]+1 cycles. Divisor 0 gives clken[i] high every cycle.
  - First pulse after reset release is on the first edge, then every active[i]+1 edges.
- Divisor update:
  - div_load[i] writes pend[i]. pend[i] is copied into active[i] on the cycle cnt[i] wraps to 0.
  - A load on the same cycle as the wrap takes effect for the following period.
  - Multiple loads before a wrap: last value wins.
  - Periods are never truncated or stretched mid-period.
- ch_enable[i] low:
  - cnt[i] held at 0, clken[i] = 0, active[i] <= pend[i] every cycle.
  - On re-enable the first pulse is on the first edge.
- Global FSM (advance = channels count; else all counters hold and clken = 0):
  - RUN: advance. pause_req=1 -> DRAIN.
  - DRAIN: advance until cnt[0]==0, then -> PAUSED without advancing that cycle; no channel-0 pulse is issued. pause_req=0 while in DRAIN -> RUN, pause_ack never asserted.
  - PAUSED: hold; pause_ack=1. pause_req=0 -> RUN (priority over step). step=1 -> STEP.
  - STEP: advance; pause_ack=0. When cnt[0] wraps back to 0 -> PAUSED. Exactly one channel-0 pulse per step; other channels advance in lockstep.
- Channel 0 disabled while in DRAIN: cnt[0]==0, so DRAIN -> PAUSED on the next cycle.
- step outside PAUSED is ignored. step pulses during STEP are ignored.
- pause_ack is registered; it rises the cycle after entry to PAUSED is decided.
- All arithmetic is unsigned CNT_W. No overflow is possible because the counter compares with >=.

Decomposition:
- Package clken_pkg holds:
  - state enum {RUN, DRAIN, PAUSED, STEP};
  - CNT_W default;
  - DEFAULT_DIV default.
- Sub-module clken_channel, instantiated NUM_CH times via generate, contains:
  - counter, pend/active registers, wrap detect, clken register;
  - inputs: advance, ch_enable, div_in, div_load.
- Top level holds the FSM and pause_ack.

Test Plan:
- Reset release, defaults -> clken[0] high on edges 1, 8, 15, 22; div_active = 6 on all channels.
- div_load[1] with 2 while cnt[1]=3 of 6 -> current 7-cycle period completes, then clken[1] every 3 cycles; div_active[1] changes at the wrap.
- Divisor 0 on channel 2 -> clken[2] constant 1; ch_enable[2]=0 -> clken[2]=0 next edge; re-enable -> pulse on first edge.
- pause_req asserted mid-period -> channel-0 period finishes, no further pulse on any channel, pause_ack=1 one cycle after entry; counters frozen for 100 cycles.
- Paused, step pulse x3 spaced 20 cycles apart -> exactly three clken[0] pulses, each 1 edge after its step, pause_ack low for 7 cycles per step.
- pause_req drop together with step in PAUSED -> RUN, free-running pulses resume at period 7; reset asserted during STEP -> all outputs 0 and state RUN immediately.
